// File: rtl/cast_pkg.sv
// Shared cast-fabric definitions: flit-type encodings carried in the top two
// flit bits and the sender's packet-tracking state.
package cast_pkg;

  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_HEAD = 2'b10;
  // 2'b11 is reserved: forwarded and credited like any flit, ignored by the FSM.

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/cast_in_fifo.sv
// First-word fall-through input FIFO for the cast credit sender: the oldest
// entry is always presented on dout while empty is low. DEPTH must be a power of 2 (>= 2).
module cast_in_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers carry one wrap bit so full and empty can be told apart.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cast_credit_sender.sv
// Credit-based flit sender: buffers upstream flits, forwards them while credits
// remain, and flags packet-framing and credit-overflow violations on err_o.
// Optional whole-packet credit reservation for HEAD flits: CAST_CREDIT_PKT_GATE_EN.
`ifndef DW
`define DW 32
`endif
`ifndef BUFFER_ALLOC
`define BUFFER_ALLOC 8
`endif
`ifndef PKT_LEN
`define PKT_LEN 4
`endif

module cast_credit_sender
  import cast_pkg::*;
#(
  parameter int DW          = `DW,
  parameter int CREDIT_INIT = `BUFFER_ALLOC,
  parameter int PKT_LEN     = `PKT_LEN,
  parameter int IN_DEPTH    = 4,
  localparam int CW         = $clog2(CREDIT_INIT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  input  logic          credit_upd_i,
  output logic [CW-1:0] credit_cnt_o,
  output logic          err_o
);

  localparam int FW = $clog2(PKT_LEN + 1) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] head;
  logic [1:0]    head_type;
  logic          accept;
  logic          send;
  logic          credit_ok;
  logic          credit_err;
  logic          fsm_err;
  logic [CW-1:0] credit_cnt;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_next;
  pkt_state_e    state;
  pkt_state_e    state_next;

  cast_in_fifo #(
    .DW    (DW),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clock (clk_i),
    .reset (rst_i),
    .push  (accept),
    .din   (data_i),
    .pop   (send),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_type = head[DW-1:DW-2];
  assign ready_o   = !fifo_full && !rst_i;
  assign accept    = valid_i && ready_o;
  assign send      = valid_o && ready_i;
  assign data_o    = head;

`ifdef CAST_CREDIT_PKT_GATE_EN
  // A new packet only starts once the receiver can hold all of it.
  assign credit_ok = (state == IDLE && head_type == FLIT_HEAD)
                   ? (int'(credit_cnt) >= PKT_LEN)
                   : (credit_cnt != '0);
`else
  assign credit_ok = (credit_cnt != '0);
`endif

  assign valid_o      = !fifo_empty && credit_ok && !rst_i;
  assign credit_cnt_o = credit_cnt;
  assign credit_err   = credit_upd_i && !send && (credit_cnt == CW'(CREDIT_INIT));

  always_ff @(posedge clk_i) begin
    if (rst_i)
      credit_cnt <= CW'(CREDIT_INIT);
    else if (send && !credit_upd_i)
      credit_cnt <= credit_cnt - CW'(1);
    else if (credit_upd_i && !send && !credit_err)
      credit_cnt <= credit_cnt + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      fcnt  <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
      if (fsm_err || credit_err)
        err_o <= 1'b1;
    end
  end

  // Framing is judged on flits actually sent; bad flits still go out.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    fsm_err    = 1'b0;
    if (send) begin
      case (state)
        IDLE: begin
          if (head_type == FLIT_HEAD) begin
            state_next = IN_PKT;
            fcnt_next  = FW'(1);
          end else if (head_type == FLIT_BODY || head_type == FLIT_TAIL) begin
            fsm_err = 1'b1;
          end
        end
        IN_PKT: begin
          if (head_type == FLIT_HEAD) begin
            fsm_err   = 1'b1;
            fcnt_next = FW'(1);
          end else if (head_type == FLIT_BODY) begin
            if (fcnt != '1)
              fcnt_next = fcnt + FW'(1);
          end else if (head_type == FLIT_TAIL) begin
            state_next = IDLE;
            fcnt_next  = '0;
            fsm_err    = (int'(fcnt) + 1 != PKT_LEN);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cast_credit_sender.sv
// Self-checking bench for cast_credit_sender (CREDIT_INIT=4, PKT_LEN=4, IN_DEPTH=4);
// expectations adapt to whether CAST_CREDIT_PKT_GATE_EN is defined.
module tb_cast_credit_sender;
  import cast_pkg::*;

  localparam int DW          = 16;
  localparam int CREDIT_INIT = 4;
  localparam int PKT_LEN     = 4;
  localparam int IN_DEPTH    = 4;
  localparam int CW          = $clog2(CREDIT_INIT + 1);

  logic          clk          = 1'b0;
  logic          rst_i        = 1'b1;
  logic          valid_i      = 1'b0;
  logic [DW-1:0] data_i       = '0;
  logic          ready_i      = 1'b0;
  logic          credit_upd_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] credit_cnt_o;
  logic          err_o;

  int            checks       = 0;
  int            errors       = 0;
  int            sent_count   = 0;
  int            model_credit = CREDIT_INIT;
  bit            mon_en       = 1'b0;
  logic [DW-1:0] sb [$];

  always #5 clk = ~clk;

  cast_credit_sender #(
    .DW          (DW),
    .CREDIT_INIT (CREDIT_INIT),
    .PKT_LEN     (PKT_LEN),
    .IN_DEPTH    (IN_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .credit_upd_i (credit_upd_i),
    .credit_cnt_o (credit_cnt_o),
    .err_o        (err_o)
  );

  // Scoreboard: accepted flits are queued, sent flits must match in order,
  // and the credit count is tracked against send/return events.
  always @(negedge clk) begin
    logic [DW-1:0] exp_flit;
    if (mon_en) begin
      if (rst_i) begin
        sb.delete();
        model_credit = CREDIT_INIT;
      end else begin
        checks++;
        if (credit_cnt_o !== CW'(model_credit)) begin
          errors++;
          $display("[TB] FAIL credit_track got %0d expected %0d", credit_cnt_o, model_credit);
        end
        if (valid_o && ready_i) begin
          sent_count++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL flit_order got %h expected no flit", data_o);
          end else begin
            exp_flit = sb.pop_front();
            if (data_o !== exp_flit) begin
              errors++;
              $display("[TB] FAIL flit_order got %h expected %h", data_o, exp_flit);
            end
          end
          if (!credit_upd_i)
            model_credit--;
        end else if (credit_upd_i && model_credit < CREDIT_INIT) begin
          model_credit++;
        end
        if (valid_i && ready_o)
          sb.push_back(data_i);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [1:0] t, input int payload);
    bit ok = 1'b0;
    valid_i = 1'b1;
    data_i  = {t, 14'(payload)};
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = ready_o;
      tick();
    end
    valid_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL push_accept got stalled expected accepted payload %0h", payload);
    end
  endtask

  task automatic push_packet(input int base);
    push_flit(FLIT_HEAD, base);
    push_flit(FLIT_BODY, base + 1);
    push_flit(FLIT_BODY, base + 2);
    push_flit(FLIT_TAIL, base + 3);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
      end else begin
        credit_upd_i = !valid_o && (model_credit < CREDIT_INIT);
        tick();
      end
    end
    credit_upd_i = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL drain got %0d flits left expected 0", sb.size());
    end
  endtask

  task automatic restore_credits();
    for (int i = 0; i < 10 && model_credit < CREDIT_INIT; i++) begin
      credit_upd_i = 1'b1;
      tick();
    end
    credit_upd_i = 1'b0;
  endtask

  task automatic do_reset();
    valid_i      = 1'b0;
    ready_i      = 1'b0;
    credit_upd_i = 1'b0;
    rst_i        = 1'b1;
    tick();
    tick();
    rst_i        = 1'b0;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    mon_en = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold got valid=%b ready=%b expected 0 0", valid_o, ready_o);
    end
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (credit_cnt_o !== CW'(CREDIT_INIT) || valid_o !== 1'b0 || err_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release got credit=%0d valid=%b err=%b ready=%b expected 4 0 0 1",
               credit_cnt_o, valid_o, err_o, ready_o);
    end
    tick();
  endtask

  task automatic test_credit_exhaustion();
    int base = sent_count;
    ready_i = 1'b1;
    push_packet('h100);
    push_packet('h200);
    repeat (3) tick();
    checks++;
    if (sent_count - base !== 4 || valid_o !== 1'b0 || credit_cnt_o !== CW'(0) || ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exhaust_stop got sent=%0d valid=%b credit=%0d ready=%b expected 4 0 0 0",
               sent_count - base, valid_o, credit_cnt_o, ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      credit_upd_i = 1'b1;
      tick();
      credit_upd_i = 1'b0;
      tick();
    end
    repeat (5) tick();
    checks++;
    if (sent_count - base !== 8 || err_o !== 1'b0 || credit_cnt_o !== CW'(0)) begin
      errors++;
      $display("[TB] FAIL exhaust_resume got sent=%0d err=%b credit=%0d expected 8 0 0",
               sent_count - base, err_o, credit_cnt_o);
    end
    restore_credits();
    checks++;
    if (credit_cnt_o !== CW'(CREDIT_INIT)) begin
      errors++;
      $display("[TB] FAIL exhaust_restore got %0d expected 4", credit_cnt_o);
    end
  endtask

  task automatic test_simultaneous();
    int base = sent_count;
    ready_i = 1'b1;
    push_flit(FLIT_HEAD, 'h300);
    push_flit(FLIT_BODY, 'h301);
    tick();
    tick();
    ready_i = 1'b0;
    push_flit(FLIT_BODY, 'h302);
    tick();
    checks++;
    if (credit_cnt_o !== CW'(2) || valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_setup got credit=%0d valid=%b expected 2 1", credit_cnt_o, valid_o);
    end
    ready_i      = 1'b1;
    credit_upd_i = 1'b1;
    tick();
    ready_i      = 1'b0;
    credit_upd_i = 1'b0;
    checks++;
    if (credit_cnt_o !== CW'(2) || sent_count - base !== 3) begin
      errors++;
      $display("[TB] FAIL simul_hold got credit=%0d sent=%0d expected 2 3", credit_cnt_o, sent_count - base);
    end
    ready_i = 1'b1;
    push_flit(FLIT_TAIL, 'h303);
    drain();
    restore_credits();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_err got %b expected 0", err_o);
    end
  endtask

  task automatic test_packet_gate();
    int base;
    ready_i = 1'b1;
    push_packet('h400);
    drain();
    for (int i = 0; i < 3; i++) begin
      credit_upd_i = 1'b1;
      tick();
    end
    credit_upd_i = 1'b0;
    checks++;
    if (credit_cnt_o !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL gate_setup got %0d expected 3", credit_cnt_o);
    end
    base = sent_count;
    push_flit(FLIT_HEAD, 'h500);
    tick();
    tick();
`ifdef CAST_CREDIT_PKT_GATE_EN
    checks++;
    if (valid_o !== 1'b0 || sent_count - base !== 0) begin
      errors++;
      $display("[TB] FAIL gate_block got valid=%b sent=%0d expected 0 0", valid_o, sent_count - base);
    end
    credit_upd_i = 1'b1;
    tick();
    credit_upd_i = 1'b0;
    tick();
    tick();
    checks++;
    if (sent_count - base !== 1 || credit_cnt_o !== CW'(3)) begin
      errors++;
      $display("[TB] FAIL gate_release got sent=%0d credit=%0d expected 1 3", sent_count - base, credit_cnt_o);
    end
`else
    checks++;
    if (sent_count - base !== 1 || credit_cnt_o !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL gate_absent got sent=%0d credit=%0d expected 1 2", sent_count - base, credit_cnt_o);
    end
`endif
    push_flit(FLIT_BODY, 'h501);
    push_flit(FLIT_BODY, 'h502);
    push_flit(FLIT_TAIL, 'h503);
    drain();
    restore_credits();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gate_err got %b expected 0", err_o);
    end
  endtask

  task automatic test_protocol_errors();
    for (int c = 0; c < 3; c++) begin
      do_reset();
      ready_i = 1'b1;
      case (c)
        0: push_flit(FLIT_BODY, 'h600);
        1: begin
          push_flit(FLIT_HEAD, 'h610);
          push_flit(FLIT_BODY, 'h611);
          push_flit(FLIT_TAIL, 'h612);
        end
        default: begin
          push_flit(FLIT_HEAD, 'h620);
          push_flit(FLIT_HEAD, 'h621);
          push_flit(FLIT_BODY, 'h622);
          push_flit(FLIT_BODY, 'h623);
          push_flit(FLIT_TAIL, 'h624);
        end
      endcase
      drain();
      tick();
      checks++;
      if (err_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL proto_case%0d got err=%b expected 1", c, err_o);
      end
    end
    do_reset();
    ready_i = 1'b1;
    push_flit(FLIT_BODY, 'h630);
    drain();
    restore_credits();
    push_packet('h640);
    drain();
    restore_credits();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL proto_sticky got %b expected 1", err_o);
    end
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_clear got %b expected 0", err_o);
    end
    credit_upd_i = 1'b1;
    tick();
    credit_upd_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b1 || credit_cnt_o !== CW'(CREDIT_INIT)) begin
      errors++;
      $display("[TB] FAIL proto_overflow got err=%b credit=%0d expected 1 4", err_o, credit_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_packet();
    int base = sent_count;
    ready_i = 1'b1;
    push_flit(FLIT_HEAD, 'h700);
    push_flit(FLIT_BODY, 'h701);
    tick();
    tick();
    checks++;
    if (sent_count - base !== 2 || credit_cnt_o !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL midrst_setup got sent=%0d credit=%0d expected 2 2", sent_count - base, credit_cnt_o);
    end
    ready_i = 1'b0;
    push_flit(FLIT_BODY, 'h702);
    do_reset();
    checks++;
    if (credit_cnt_o !== CW'(CREDIT_INIT) || valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_state got credit=%0d valid=%b err=%b expected 4 0 0",
               credit_cnt_o, valid_o, err_o);
    end
    ready_i = 1'b1;
    push_packet('h800);
    drain();
    tick();
    restore_credits();
    checks++;
    if (err_o !== 1'b0 || credit_cnt_o !== CW'(CREDIT_INIT)) begin
      errors++;
      $display("[TB] FAIL midrst_after got err=%b credit=%0d expected 0 4", err_o, credit_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_credit_exhaustion();
    test_simultaneous();
    test_packet_gate();
    test_protocol_errors();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cast_credit_sender.md
CAST_CREDIT_SENDER -- requirements
Module: cast_credit_sender

Interface
REQ-001 SHALL have parameter DW, default `DW, flit width; bits [DW-1:DW-2] are the flit type.
REQ-002 SHALL have parameter CREDIT_INIT, default `BUFFER_ALLOC, downstream receive-buffer depth in flits.
REQ-003 SHALL have parameter PKT_LEN, default `PKT_LEN, flits per packet, HEAD and TAIL included.
REQ-004 SHALL have parameter IN_DEPTH, default 4, input FIFO depth (power of 2).
REQ-005 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port valid_i  input  1  upstream flit valid.
REQ-008 SHALL have port data_i  input  DW  upstream flit.
REQ-009 SHALL have port ready_o  output  1  upstream ready; equals input FIFO not full.
REQ-010 SHALL have port valid_o  output  1  flit offered to the downstream cast receive buffer.
REQ-011 SHALL have port data_o  output  DW  input FIFO head flit.
REQ-012 SHALL have port ready_i  input  1  downstream ready.
REQ-013 SHALL have port credit_upd_i  input  1  one-cycle pulse returning one buffer credit.
REQ-014 SHALL have port credit_cnt_o  output  CW  current credits, CW = $clog2(CREDIT_INIT+1).
REQ-015 SHALL have port err_o  output  1  sticky protocol error.

Function
REQ-016 Accept = valid_i & ready_o; send = valid_o & ready_i.
REQ-017 Input FIFO SHALL be first-word fall-through, so a flit accepted in cycle N is visible on data_o in cycle N+1.
REQ-018 Without the gate feature, valid_o = FIFO non-empty & credit_cnt >= 1.
REQ-019 On send & ~credit_upd_i, the credit counter SHALL decrement by 1.
REQ-020 On credit_upd_i & ~send, the credit counter SHALL increment by 1.
REQ-021 On send & credit_upd_i in the same cycle, the credit counter SHALL be unchanged.
REQ-022 An increment at credit_cnt = CREDIT_INIT SHALL saturate at CREDIT_INIT and set err_o.
REQ-023 The packet FSM SHALL have states IDLE and IN_PKT, with a flit counter fcnt.
REQ-024 A sent HEAD in IDLE SHALL move the FSM to IN_PKT with fcnt = 1.
REQ-025 Each sent BODY in IN_PKT SHALL do fcnt += 1.
REQ-026 A sent TAIL in IN_PKT SHALL return the FSM to IDLE.
REQ-027 Sending BODY or TAIL in IDLE SHALL set err_o, with the FSM remaining in IDLE.
REQ-028 Sending HEAD in IN_PKT SHALL set err_o and restart with fcnt = 1.
REQ-029 A sent TAIL with fcnt+1 != PKT_LEN SHALL set err_o.
REQ-030 Erroneous flits SHALL still be forwarded; err_o SHALL only record the violation.
REQ-031 Simultaneous accept and send on a full FIFO SHALL NOT be allowed: ready_o is low when full, with no bypass.
REQ-032 data_o SHALL be don't-care while valid_o = 0.

Reset
REQ-033 While rst_i = 1: FIFO emptied, FSM = IDLE, fcnt = 0, credit_cnt = CREDIT_INIT, err_o = 0.
REQ-034 While rst_i = 1: valid_o = 0, ready_o = 0.
REQ-035 Reset mid-packet SHALL discard buffered flits and all in-flight packet state.

Configuration
REQ-036 The feature SHALL be controlled by macro CAST_CREDIT_PKT_GATE_EN.
REQ-037 When CAST_CREDIT_PKT_GATE_EN is defined, in IDLE a HEAD flit SHALL assert valid_o only if credit_cnt >= PKT_LEN, so whole-packet space is reserved.
REQ-038 When CAST_CREDIT_PKT_GATE_EN is defined, IN_PKT flits SHALL use the REQ-018 rule.
REQ-039 When CAST_CREDIT_PKT_GATE_EN is undefined, REQ-018 SHALL apply to all flits, and the gate logic SHALL be absent from the netlist.

Structure
REQ-040 Flit-type constants (HEAD, BODY, TAIL) and the FSM state enum SHALL reside in the shared package cast_pkg.
REQ-041 The input FIFO SHALL be the sub-module cast_in_fifo (FWFT, synchronous active-high reset); credit and FSM logic SHALL be in the top module.

Verification (CREDIT_INIT=4, PKT_LEN=4, IN_DEPTH=4)
REQ-042 Reset: rst_i=1 for 2 cycles -> credit_cnt_o=4, valid_o=0, err_o=0, ready_o=1 on the first cycle after release.
REQ-043 Credit exhaustion: 2 well-formed packets (8 flits), ready_i=1, no credit_upd_i -> exactly 4 flits sent, then valid_o=0 with credit_cnt_o=0; 4 credit_upd_i pulses -> the remaining 4 flits sent, err_o=0.
REQ-044 Simultaneous events: credit_cnt_o=2, send and credit_upd_i in the same cycle -> credit_cnt_o stays 2.
REQ-045 Packet gate: credit_cnt_o=3 with HEAD at FIFO head -> with the macro defined, valid_o=0 until one credit_upd_i, then HEAD sent; with the macro undefined, HEAD sent immediately.
REQ-046 Protocol errors: BODY sent in IDLE -> err_o=1, held until reset; separately, credit_upd_i at credit_cnt_o=4 -> err_o=1 and credit_cnt_o stays 4.
REQ-047 Reset mid-packet: rst_i=1 after HEAD and 1 BODY sent -> FSM IDLE, credit_cnt_o=4; a new full packet afterwards -> err_o=0.
